// File: rtl/sap_pkg.sv
// Shared SAP-style constants: opcodes, microstep encodings, per-opcode lengths
// and the packed control-word layout used by the sequencer.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_in;
        logic ram_out;
        logic ram_in;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic out_in;
        logic alu_enable;
        logic sub;
        logic inc_a;
        logic dec_a;
    } ctrl_t;

    // Total cycles per instruction, fetch included; unlisted opcodes run as NOP.
    function automatic logic [2:0] instr_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: instr_len = 3'd4;
            OP_ADD, OP_SUB: instr_len = 3'd5;
            default:        instr_len = 3'd3;
        endcase
    endfunction

    function automatic tstate_t last_step(input logic [3:0] op);
        last_step = tstate_t'(instr_len(op) - 3'd1);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Carry/zero flag register with load enable and synchronous active-low clear.
module flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic c,
    input  logic z,
    output logic cf,
    output logic zf
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cf <= 1'b0;
            zf <= 1'b0;
        end else if (load) begin
            cf <= c;
            zf <= z;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microstep counter and combinational control decode for the SAP-style core;
// flags live in flag_reg.
module control_sequencer
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       c,
    input  logic       z,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       out_in,
    output logic       alu_enable,
    output logic       sub,
    output logic       inc_a,
    output logic       dec_a,
    output logic       cf,
    output logic       zf,
    output logic       halted,
    output logic [2:0] t_state
);

    tstate_t state, state_nxt, step;
    logic    halted_q, halted_nxt;
    logic    flag_ld;
    ctrl_t   ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= T0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            halted_q <= halted_nxt;
        end
    end

    // Reset forces the T0 decode regardless of where the counter was left.
    always_comb begin
        step       = rst_n ? state : T0;
        ctrl       = '0;
        flag_ld    = 1'b0;
        state_nxt  = T0;
        halted_nxt = halted_q;

        if (!halted_q || !rst_n) begin
            case (step)
                T0: begin
                    ctrl.pc_out = 1'b1;
                    ctrl.mar_in = 1'b1;
                end
                T1: begin
                    ctrl.ram_out = 1'b1;
                    ctrl.ir_in   = 1'b1;
                    ctrl.pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl.ir_out = 1'b1;
                            ctrl.mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl.ir_out = 1'b1;
                            ctrl.a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl.ir_out  = 1'b1;
                            ctrl.pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ctrl.ir_out  = cf;
                            ctrl.pc_load = cf;
                        end
                        OP_JZ: begin
                            ctrl.ir_out  = zf;
                            ctrl.pc_load = zf;
                        end
                        OP_INC, OP_DEC: begin
                            ctrl.inc_a      = (opcode == OP_INC);
                            ctrl.dec_a      = (opcode == OP_DEC);
                            ctrl.alu_enable = 1'b1;
                            ctrl.a_in       = 1'b1;
                            flag_ld         = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.a_out  = 1'b1;
                            ctrl.out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ctrl.ram_out = 1'b1;
                            ctrl.a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ram_out = 1'b1;
                            ctrl.b_in    = 1'b1;
                        end
                        OP_STA: begin
                            ctrl.a_out  = 1'b1;
                            ctrl.ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctrl.alu_enable = 1'b1;
                        ctrl.a_in       = 1'b1;
                        ctrl.sub        = (opcode == OP_SUB);
                        flag_ld         = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // >= rather than == keeps the counter bounded if opcode shifts mid-instruction.
        if (!halted_q) begin
            if (state >= last_step(opcode)) state_nxt = T0;
            else                            state_nxt = tstate_t'(state + 3'd1);
            if (state == T2 && opcode == OP_HLT) halted_nxt = 1'b1;
        end
    end

    flag_reg u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (flag_ld && rst_n),
        .c     (c),
        .z     (z),
        .cf    (cf),
        .zf    (zf)
    );

    assign pc_out     = ctrl.pc_out;
    assign pc_inc     = ctrl.pc_inc;
    assign pc_load    = ctrl.pc_load;
    assign mar_in     = ctrl.mar_in;
    assign ram_out    = ctrl.ram_out;
    assign ram_in     = ctrl.ram_in;
    assign ir_in      = ctrl.ir_in;
    assign ir_out     = ctrl.ir_out;
    assign a_in       = ctrl.a_in;
    assign a_out      = ctrl.a_out;
    assign b_in       = ctrl.b_in;
    assign out_in     = ctrl.out_in;
    assign alu_enable = ctrl.alu_enable;
    assign sub        = ctrl.sub;
    assign inc_a      = ctrl.inc_a;
    assign dec_a      = ctrl.dec_a;
    assign halted     = halted_q;
    assign t_state    = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-microstep control words, flags,
// halt and reset behaviour, plus a bus-driver exclusivity monitor.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       c, z;
    logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       a_in, a_out, b_in, out_in, alu_enable, sub, inc_a, dec_a;
    logic       cf, zf, halted;
    logic [2:0] t_state;
    logic [15:0] cv;
    logic        mon_en = 1'b0;

    int checks = 0;
    int fails  = 0;

    localparam logic [15:0] PC_OUT  = 16'h8000, PC_INC = 16'h4000, PC_LOAD = 16'h2000,
                            MAR_IN  = 16'h1000, RAM_OUT = 16'h0800, RAM_IN = 16'h0400,
                            IR_IN   = 16'h0200, IR_OUT = 16'h0100, A_IN = 16'h0080,
                            A_OUT   = 16'h0040, B_IN = 16'h0020, OUT_IN = 16'h0010,
                            ALU_EN  = 16'h0008, SUB = 16'h0004, INC_A = 16'h0002,
                            DEC_A   = 16'h0001;
    localparam logic [15:0] FETCH0 = PC_OUT | MAR_IN;
    localparam logic [15:0] FETCH1 = RAM_OUT | IR_IN | PC_INC;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .c(c), .z(z),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .out_in(out_in),
        .alu_enable(alu_enable), .sub(sub), .inc_a(inc_a), .dec_a(dec_a),
        .cf(cf), .zf(zf), .halted(halted), .t_state(t_state)
    );

    assign cv = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                 a_in, a_out, b_in, out_in, alu_enable, sub, inc_a, dec_a};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ts(input string tag, input int t, input logic [15:0] e);
        chk({tag, "_t"}, 32'(t_state), 32'(t));
        chk({tag, "_ctl"}, 32'(cv), 32'(e));
        step();
    endtask

    // len cycles total; e2..e4 are the expected execute-step control words.
    task automatic run(input string tag, input logic [3:0] op, input int len,
                       input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        opcode = op;
        ts({tag, "0"}, 0, FETCH0);
        ts({tag, "1"}, 1, FETCH1);
        ts({tag, "2"}, 2, e2);
        if (len > 3) ts({tag, "3"}, 3, e3);
        if (len > 4) ts({tag, "4"}, 4, e4);
        chk({tag, "_end"}, 32'(t_state), 32'd0);
    endtask

    // Bus drivers one-hot-or-zero and ALU selects exclusive, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("bus_onehot", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_enable}) <= 1), 32'd1);
            chk("alu_sel_excl", 32'($countones({sub, inc_a, dec_a}) <= 1), 32'd1);
        end
    end

    initial begin
        rst_n = 1'b0; opcode = 4'h0; c = 1'b0; z = 1'b0;
        step(); step();
        chk("rst_t", 32'(t_state), 32'd0);
        chk("rst_ctl", 32'(cv), 32'(FETCH0));
        chk("rst_flags", 32'({cf, zf}), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        rst_n = 1'b1;

        run("nop", 4'h0, 3, 16'h0, 16'h0, 16'h0);

        c = 1'b1; z = 1'b0;
        run("add", 4'h2, 5, IR_OUT | MAR_IN, RAM_OUT | B_IN, ALU_EN | A_IN);
        chk("add_flags", 32'({cf, zf}), 32'b10);

        c = 1'b0; z = 1'b1;
        run("sub", 4'h3, 5, IR_OUT | MAR_IN, RAM_OUT | B_IN, ALU_EN | A_IN | SUB);
        chk("sub_flags", 32'({cf, zf}), 32'b01);

        z = 1'b0;
        run("jz", 4'h8, 3, IR_OUT | PC_LOAD, 16'h0, 16'h0);
        chk("jz_flags", 32'({cf, zf}), 32'b01);

        c = 1'b1;
        run("jc0", 4'h7, 3, 16'h0, 16'h0, 16'h0);
        chk("jc0_cf", 32'(cf), 32'd0);

        run("lda", 4'h1, 4, IR_OUT | MAR_IN, RAM_OUT | A_IN, 16'h0);
        run("sta", 4'h4, 4, IR_OUT | MAR_IN, A_OUT | RAM_IN, 16'h0);

        c = 1'b1; z = 1'b1;
        run("inc", 4'h9, 3, INC_A | ALU_EN | A_IN, 16'h0, 16'h0);
        chk("inc_flags", 32'({cf, zf}), 32'b11);

        c = 1'b0; z = 1'b0;
        run("jc1", 4'h7, 3, IR_OUT | PC_LOAD, 16'h0, 16'h0);
        run("dec", 4'hA, 3, DEC_A | ALU_EN | A_IN, 16'h0, 16'h0);
        chk("dec_flags", 32'({cf, zf}), 32'b00);

        run("ldi", 4'h5, 3, IR_OUT | A_IN, 16'h0, 16'h0);
        run("jmp", 4'h6, 3, IR_OUT | PC_LOAD, 16'h0, 16'h0);
        run("out", 4'hE, 3, A_OUT | OUT_IN, 16'h0, 16'h0);
        run("opc", 4'hC, 3, 16'h0, 16'h0, 16'h0);
        chk("opc_flags", 32'({cf, zf}), 32'b00);

        run("hlt", 4'hF, 3, 16'h0, 16'h0, 16'h0);
        chk("hlt_halt", 32'(halted), 32'd1);
        chk("hlt_ctl", 32'(cv), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("hlt10_t", 32'(t_state), 32'd0);
        chk("hlt10_ctl", 32'(cv), 32'd0);
        chk("hlt10_halt", 32'(halted), 32'd1);
        rst_n = 1'b0;
        step();
        chk("unhalt", 32'(halted), 32'd0);
        chk("unhalt_t", 32'(t_state), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("unhalt_ctl", 32'(cv), 32'(FETCH0));

        // Set both flags, then reset in the middle of an ADD.
        c = 1'b1; z = 1'b1;
        run("inc2", 4'h9, 3, INC_A | ALU_EN | A_IN, 16'h0, 16'h0);
        chk("inc2_flags", 32'({cf, zf}), 32'b11);
        opcode = 4'h2;
        ts("addr0", 0, FETCH0);
        ts("addr1", 1, FETCH1);
        ts("addr2", 2, IR_OUT | MAR_IN);
        chk("addr3_ctl", 32'(cv), 32'(RAM_OUT | B_IN));
        rst_n = 1'b0;
        #1;
        chk("addr3_rstctl", 32'(cv), 32'(FETCH0));
        step();
        chk("addr_t", 32'(t_state), 32'd0);
        chk("addr_flags", 32'({cf, zf}), 32'b00);
        step();
        chk("addr_hold_t", 32'(t_state), 32'd0);
        chk("addr_hold_flags", 32'({cf, zf}), 32'b00);
        rst_n = 1'b1;
        ts("restart0", 0, FETCH0);
        chk("restart1", 32'(t_state), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        mon_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (t_state == 3'd0) opcode = 4'($urandom_range(0, 14));
            c = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            step();
        end
        mon_en = 1'b0;
        chk("rand_nohalt", 32'(halted), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset; all state changes SHALL occur on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous reset, active-low.
REQ-004 opcode  input  4  upper nibble of the instruction register, valid from T2 onward.
REQ-005 c  input  1  ALU carry output (combinational).
REQ-006 z  input  1  ALU zero output (combinational).
REQ-007 pc_out, pc_inc, pc_load  output  1 each  program counter drive to bus, increment, and load from bus.
REQ-008 mar_in, ram_out, ram_in  output  1 each  MAR load, RAM drive to bus, RAM write.
REQ-009 ir_in, ir_out  output  1 each  IR load; IR low nibble zero-extended onto the bus.
REQ-010 a_in, a_out, b_in, out_in  output  1 each  A load, A drive to bus, B load, output-register load.
REQ-011 alu_enable, sub, inc_a, dec_a  output  1 each  ALU bus drive and ALU operation select.
REQ-012 cf, zf  output  1 each  latched carry and zero flags.
REQ-013 halted  output  1  processor stopped.
REQ-014 t_state  output  3  current microstep (0-4), debug only.

Function
REQ-015 The step counter SHALL advance T0->T1->T2->..., and SHALL return to T0 on the edge after each instruction's last microstep, with no idle steps.
REQ-016 All control outputs SHALL be combinational decodes of (t_state, opcode, cf, zf, halted); any control line not listed for a step SHALL be 0.
REQ-017 Fetch SHALL be: T0 = pc_out, mar_in; T1 = ram_out, ir_in, pc_inc.
REQ-018 Execute steps and total lengths SHALL be:
  - NOP 0x0: none; 3 cycles.
  - LDA 0x1: T2 ir_out, mar_in; T3 ram_out, a_in; 4 cycles.
  - ADD 0x2: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_enable, a_in, flag update; 5 cycles.
  - SUB 0x3: same as ADD, with sub=1 at T4.
  - STA 0x4: T2 ir_out, mar_in; T3 a_out, ram_in; 4 cycles.
  - LDI 0x5: T2 ir_out, a_in.
  - JMP 0x6: T2 ir_out, pc_load.
  - JC 0x7: T2 ir_out, pc_load only if cf=1, otherwise no controls.
  - JZ 0x8: T2 ir_out, pc_load only if zf=1, otherwise no controls.
  - INC 0x9: T2 inc_a, alu_enable, a_in, flag update.
  - DEC 0xA: T2 dec_a, alu_enable, a_in, flag update.
  - OUT 0xE: T2 a_out, out_in.
  - HLT 0xF: T2 sets halted.
  - LDI, JMP, JC, JZ, INC, DEC, OUT and HLT each take 3 cycles.
REQ-019 Opcodes 0xB-0xD SHALL execute as NOP.
REQ-020 On a flag-update step, cf<=c and zf<=z SHALL be captured on that step's closing edge; at all other times cf and zf SHALL hold.
REQ-021 JC/JZ SHALL test the flag values registered before T2, not the live c and z inputs.
REQ-022 At most one of pc_out, ram_out, ir_out, a_out, alu_enable SHALL be 1 in any cycle.
REQ-023 When halted=1, the counter SHALL freeze at T0, all control outputs SHALL be 0, and only reset SHALL clear halted.
REQ-024 sub, inc_a and dec_a SHALL be mutually exclusive.

Reset
REQ-025 With rst_n=0 at a clock edge, the block SHALL set t_state=0, cf=0, zf=0, halted=0, abandoning any instruction in progress; fetch SHALL restart at T0 on the first edge with rst_n=1.
REQ-026 While rst_n=0, control outputs SHALL equal their T0 decode; no flag update SHALL occur during reset.

Structure
REQ-027 Opcode constants, T-state encodings and per-opcode step counts SHALL live in the shared package sap_pkg.
REQ-028 The flag register (cf, zf with load enable) SHALL be a sub-module named flag_reg; the decode and step counter SHALL remain in control_sequencer.

Verification
REQ-029 Reset then NOP -> t_state 0,1,2,0; pc_out=1 only at T0, ir_in=1 only at T1.
REQ-030 ADD with c=1, z=0 at T4 -> alu_enable, a_in at T4 with sub=0; cf=1, zf=0 after the edge; t_state returns to 0.
REQ-031 SUB with z=1, then JZ -> sub=1 at T4; zf=1; at JZ T2 pc_load=1 and ir_out=1.
REQ-032 JC with cf=0 while c=1 is driven live -> pc_load=0 at T2; cf stays 0.
REQ-033 HLT, then 10 cycles -> halted=1, t_state=0, all controls 0; rst_n=0 for one edge -> halted=0.
REQ-034 rst_n=0 at ADD T3, plus a bus-driver one-hot assertion over a random opcode stream -> t_state=0, flags 0, no flag update; assertion never fires.
